// File: rtl/joypad_port.sv
// NES controller ports at $4016/$4017: strobe register, per-pad button
// synchronizers and 8-bit serial shift registers read one bit per CPU read.
module joypad_port #(
   parameter logic [15:0] PORT1_ADDR  = 16'h4016,
   parameter logic [15:0] PORT2_ADDR  = 16'h4017,
   parameter logic [2:0]  OPEN_BUS_HI = 3'b010
) (
   input  logic        clk_ph1,
   input  logic        rst,
   input  logic [15:0] addr,
   input  logic [7:0]  cpu_dout,
   input  logic        R_nW,
   input  logic [7:0]  pad1_btn,
   input  logic [7:0]  pad2_btn,
   output logic [7:0]  rd_data,
   output logic        rd_sel,
   output logic        strobe
);

   logic [7:0] sync1_a, sync1_b;
   logic [7:0] sync2_a, sync2_b;
   logic [7:0] sr1, sr2;
   logic       rd1, rd2, wr1;

   assign rd1 = R_nW & (addr == PORT1_ADDR);
   assign rd2 = R_nW & (addr == PORT2_ADDR);
   assign wr1 = ~R_nW & (addr == PORT1_ADDR);

   always_comb begin
      rd_data = 8'h00;
      if (rd1)
         rd_data = {OPEN_BUS_HI, 4'b0000, sr1[0]};
      else if (rd2)
         rd_data = {OPEN_BUS_HI, 4'b0000, sr2[0]};
   end

   assign rd_sel = rd1 | rd2;

   // Two-flop synchronizers for the asynchronous pad buttons
   always_ff @(posedge clk_ph1) begin
      if (!rst) begin
         sync1_a <= 8'h00;
         sync1_b <= 8'h00;
         sync2_a <= 8'h00;
         sync2_b <= 8'h00;
      end else begin
         sync1_a <= pad1_btn;
         sync1_b <= sync1_a;
         sync2_a <= pad2_btn;
         sync2_b <= sync2_a;
      end
   end

   // Load uses the pre-edge strobe, so the write that clears it still latches once
   always_ff @(posedge clk_ph1) begin
      if (!rst) begin
         strobe <= 1'b0;
         sr1    <= 8'hFF;
         sr2    <= 8'hFF;
      end else begin
         if (wr1)
            strobe <= cpu_dout[0];
         if (strobe) begin
            sr1 <= sync1_b;
            sr2 <= sync2_b;
         end else if (rd1) begin
            sr1 <= {1'b1, sr1[7:1]};
         end else if (rd2) begin
            sr2 <= {1'b1, sr2[7:1]};
         end
      end
   end

endmodule

// File: tb/tb_joypad_port.sv
// Bench for joypad_port: directed scenarios plus randomized bus traffic
// checked against a button-latch / read-count reference model.
module tb_joypad_port;

   logic        clk_ph1;
   logic        rst;
   logic [15:0] addr;
   logic [7:0]  cpu_dout;
   logic        R_nW;
   logic [7:0]  pad1_btn;
   logic [7:0]  pad2_btn;
   logic [7:0]  rd_data;
   logic        rd_sel;
   logic        strobe;

   int checks = 0;
   int errors = 0;

   joypad_port dut (
      .clk_ph1 (clk_ph1),
      .rst     (rst),
      .addr    (addr),
      .cpu_dout(cpu_dout),
      .R_nW    (R_nW),
      .pad1_btn(pad1_btn),
      .pad2_btn(pad2_btn),
      .rd_data (rd_data),
      .rd_sel  (rd_sel),
      .strobe  (strobe)
   );

   initial begin
      clk_ph1 = 1'b0;
      forever #5 clk_ph1 = ~clk_ph1;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not reach summary");
      $fatal(1, "timeout");
   end

   // Reference model: latched button byte, number of reads since latch,
   // and the pad values seen at the last two edges (synchronizer delay).
   logic       m_strobe;
   logic [7:0] m_lat1, m_lat2;
   int         m_k1, m_k2;
   logic [7:0] p1_h1, p1_h2, p2_h1, p2_h2;

   function automatic logic m_bit(input logic [7:0] lat, input int k);
      return (k < 8) ? lat[k] : 1'b1;
   endfunction

   function automatic logic [7:0] exp_rd();
      if (R_nW && addr == 16'h4016) return {3'b010, 4'b0000, m_bit(m_lat1, m_k1)};
      if (R_nW && addr == 16'h4017) return {3'b010, 4'b0000, m_bit(m_lat2, m_k2)};
      return 8'h00;
   endfunction

   function automatic logic exp_sel();
      return R_nW && (addr == 16'h4016 || addr == 16'h4017);
   endfunction

   task automatic drive(input logic [15:0] a, input logic rnw, input logic [7:0] d);
      addr = a;
      R_nW = rnw;
      cpu_dout = d;
      @(negedge clk_ph1);
   endtask

   task automatic tick();
      logic pre;
      @(posedge clk_ph1);
      if (!rst) begin
         m_strobe = 1'b0;
         m_lat1 = 8'hFF; m_lat2 = 8'hFF;
         m_k1 = 0; m_k2 = 0;
         p1_h1 = 8'h00; p1_h2 = 8'h00; p2_h1 = 8'h00; p2_h2 = 8'h00;
      end else begin
         pre = m_strobe;
         if (!R_nW && addr == 16'h4016) m_strobe = cpu_dout[0];
         if (pre) begin
            m_lat1 = p1_h2; m_lat2 = p2_h2;
            m_k1 = 0; m_k2 = 0;
         end else if (R_nW && addr == 16'h4016) begin
            if (m_k1 < 8) m_k1++;
         end else if (R_nW && addr == 16'h4017) begin
            if (m_k2 < 8) m_k2++;
         end
         p1_h2 = p1_h1; p1_h1 = pad1_btn;
         p2_h2 = p2_h1; p2_h1 = pad2_btn;
      end
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         drive(16'h0000, 1'b1, 8'h00);
         tick();
      end
   endtask

   task automatic pulse();
      drive(16'h4016, 1'b0, 8'h01); tick();
      drive(16'h4016, 1'b0, 8'h00); tick();
   endtask

   task automatic test_reset();
      rst = 1'b0;
      tick(); tick();
      rst = 1'b1;
      drive(16'h0000, 1'b1, 8'h00);
      checks++;
      if (strobe !== 1'b0 || rd_sel !== 1'b0 || rd_data !== 8'h00) begin
         errors++;
         $display("FAIL reset_idle strobe=%b rd_sel=%b rd_data=%h exp 0/0/00", strobe, rd_sel, rd_data);
      end
      tick();
      for (int i = 0; i < 3; i++) begin
         drive(16'h4016, 1'b1, 8'h00);
         checks++;
         if (rd_sel !== 1'b1 || rd_data !== 8'h41) begin
            errors++;
            $display("FAIL reset_read%0d rd_sel=%b rd_data=%h exp 1/41", i, rd_sel, rd_data);
         end
         tick();
      end
   endtask

   task automatic test_serial();
      logic [8:0] seq;
      seq = 9'b1_1001_0101;
      pad1_btn = 8'b1001_0101;
      idle(3);
      pulse();
      for (int i = 0; i < 9; i++) begin
         drive(16'h4016, 1'b1, 8'h00);
         checks++;
         if (rd_data !== {7'b0100000, seq[i]} || rd_data !== exp_rd()) begin
            errors++;
            $display("FAIL serial_read%0d rd_data=%h exp %h", i, rd_data, {7'b0100000, seq[i]});
         end
         tick();
      end
   endtask

   task automatic test_strobe_hold();
      pad1_btn = 8'h00;
      idle(3);
      drive(16'h4016, 1'b0, 8'h01); tick();
      idle(3);
      pad1_btn = 8'h01;
      for (int j = 0; j < 6; j++) begin
         drive(16'h4016, 1'b1, 8'h00);
         checks++;
         if (rd_data[0] !== (j >= 3) || strobe !== 1'b1 || rd_data !== exp_rd()) begin
            errors++;
            $display("FAIL strobe_hold%0d bit=%b strobe=%b exp bit=%b strobe=1", j, rd_data[0], strobe, (j >= 3));
         end
         tick();
      end
      drive(16'h4016, 1'b0, 8'h00); tick();
   endtask

   task automatic test_pad2();
      pad2_btn = 8'h80;
      pad1_btn = 8'($urandom);
      idle(3);
      pulse();
      for (int i = 0; i < 8; i++) begin
         drive(16'h4017, 1'b1, 8'h00);
         checks++;
         if (rd_data !== {7'b0100000, (i == 7)}) begin
            errors++;
            $display("FAIL pad2_read%0d rd_data=%h exp %h", i, rd_data, {7'b0100000, (i == 7)});
         end
         tick();
         drive(16'h4016, 1'b1, 8'h00);
         checks++;
         if (rd_data !== {7'b0100000, pad1_btn[i]}) begin
            errors++;
            $display("FAIL pad1_interleave%0d rd_data=%h exp %h", i, rd_data, {7'b0100000, pad1_btn[i]});
         end
         tick();
      end
   endtask

   task automatic test_ignored_writes();
      logic [7:0] r;
      r = 8'($urandom);
      pad1_btn = r;
      idle(3);
      pulse();
      drive(16'h4016, 1'b1, 8'h00); tick();
      drive(16'h4017, 1'b0, 8'h01); tick();
      drive(16'h0000, 1'b1, 8'h00);
      checks++;
      if (strobe !== 1'b0) begin
         errors++;
         $display("FAIL wr4017_strobe strobe=%b exp 0", strobe);
      end
      tick();
      drive(16'h4016, 1'b0, 8'hFE); tick();
      drive(16'h5000, 1'b1, 8'h00);
      checks++;
      if (strobe !== 1'b0 || rd_sel !== 1'b0 || rd_data !== 8'h00) begin
         errors++;
         $display("FAIL rd5000 strobe=%b rd_sel=%b rd_data=%h exp 0/0/00", strobe, rd_sel, rd_data);
      end
      tick();
      drive(16'h4016, 1'b1, 8'h00);
      checks++;
      if (rd_data !== {7'b0100000, r[1]}) begin
         errors++;
         $display("FAIL untouched_sr rd_data=%h exp %h", rd_data, {7'b0100000, r[1]});
      end
      tick();
   endtask

   task automatic test_reset_mid();
      pad1_btn = 8'h00;
      pad2_btn = 8'h00;
      idle(3);
      pulse();
      for (int i = 0; i < 3; i++) begin
         drive(16'h4016, 1'b1, 8'h00);
         checks++;
         if (rd_data !== 8'h40) begin
            errors++;
            $display("FAIL premid_read%0d rd_data=%h exp 40", i, rd_data);
         end
         tick();
      end
      rst = 1'b0;
      drive(16'h0000, 1'b1, 8'h00); tick();
      rst = 1'b1;
      for (int i = 0; i < 2; i++) begin
         drive((i == 0) ? 16'h4016 : 16'h4017, 1'b1, 8'h00);
         checks++;
         if (rd_data !== 8'h41 || strobe !== 1'b0) begin
            errors++;
            $display("FAIL postreset_read%0d rd_data=%h strobe=%b exp 41/0", i, rd_data, strobe);
         end
         tick();
      end
   endtask

   task automatic test_random();
      logic [15:0] a;
      for (int n = 0; n < 600; n++) begin
         rst = ($urandom_range(0, 99) != 0);
         if ($urandom_range(0, 3) == 0) pad1_btn = 8'($urandom);
         if ($urandom_range(0, 3) == 0) pad2_btn = 8'($urandom);
         case ($urandom_range(0, 5))
            0, 1:    a = 16'h4016;
            2, 3:    a = 16'h4017;
            4:       a = 16'h5000;
            default: a = 16'($urandom);
         endcase
         drive(a, ($urandom_range(0, 3) != 0), 8'($urandom));
         checks++;
         if (rd_data !== exp_rd() || rd_sel !== exp_sel() || strobe !== m_strobe) begin
            errors++;
            $display("FAIL random%0d addr=%h rnw=%b rd_data=%h rd_sel=%b strobe=%b exp %h/%b/%b",
                     n, addr, R_nW, rd_data, rd_sel, strobe, exp_rd(), exp_sel(), m_strobe);
         end
         tick();
      end
      rst = 1'b1;
   endtask

   initial begin
      rst = 1'b0;
      addr = 16'h0000;
      R_nW = 1'b1;
      cpu_dout = 8'h00;
      pad1_btn = 8'h00;
      pad2_btn = 8'h00;
      tick();
      test_reset();
      test_serial();
      test_strobe_hold();
      test_pad2();
      test_ignored_writes();
      test_reset_mid();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/joypad_port.md
Name: joypad_port

Overview:
- CPU-bus responder for the two NES controller ports at $4016/$4017.
- The CPU initiates the accesses. This block decodes them, holds the controller strobe written via $4016, latches button state into per-pad 8-bit shift registers, and returns one serial bit per read.
- Sits beside the memory map on the CPU address/data bus.
- Button inputs are parallel, come from board-level pad logic, and are asynchronous.

Parameters:
- PORT1_ADDR, 16'h4016, address for strobe write and pad 1 read.
- PORT2_ADDR, 16'h4017, address for pad 2 read (writes here are ignored; they belong to the APU frame counter).
- OPEN_BUS_HI, 3'b010, value driven on rd_data[7:5] during a port read (emulates open-bus $40).

Ports:
- clk_ph1  in  1  CPU phase-1 clock; all state updates on posedge.
- rst  in  1  synchronous, active-low reset.
- addr  in  16  CPU address bus. Changes only at posedge clk_ph1.
- cpu_dout  in  8  CPU output data bus. Valid for the whole cycle when R_nW=0.
- R_nW  in  1  CPU read/not-write. Registered by the CPU with addr.
- pad1_btn  in  8  pad 1 buttons, 1 = pressed, asynchronous. Bit order: 0 A, 1 B, 2 Select, 3 Start, 4 Up, 5 Down, 6 Left, 7 Right.
- pad2_btn  in  8  pad 2 buttons, same encoding.
- rd_data  out  8  read data to the CPU data-in mux. Combinational.
- rd_sel  out  1  1 when this block owns the current read cycle (mux select).
- strobe  out  1  registered controller strobe (OUT0), for external pads/debug.

Behaviour:
- Reset (rst=0 at posedge):
  - strobe=0.
  - sr1=sr2=8'hFF.
  - Synchronizer flops = 8'h00.
  - rd_sel and rd_data follow the decode and are 0 when no port is addressed.
- Synchronizer: each padN_btn passes through two flops (syncN_a -> syncN_b). Total latency from input change to syncN_b is 2 clk_ph1 edges.
- Access decode (combinational on current bus values):
  - rd1 = R_nW & (addr==PORT1_ADDR).
  - rd2 = R_nW & (addr==PORT2_ADDR).
  - wr1 = ~R_nW & (addr==PORT1_ADDR).
- Read data (combinational, stable for the whole cycle so the CPU's ph2 latch captures it):
  - rd1 -> rd_data = {OPEN_BUS_HI, 4'b0000, sr1[0]}.
  - rd2 -> rd_data = {OPEN_BUS_HI, 4'b0000, sr2[0]}.
  - Otherwise rd_data = 8'h00.
  - rd_sel = rd1 | rd2.
- Commit at end of cycle (posedge clk_ph1, using bus values present before the edge):
  - wr1: strobe <= cpu_dout[0]. Bits 7:1 are ignored.
  - Load rule: if strobe (pre-edge value) is 1, sr1 <= sync1_b and sr2 <= sync2_b. The write that clears strobe therefore performs the final latch on its own edge.
  - Shift rule: else if rd1, sr1 <= {1'b1, sr1[7:1]}; else if rd2, sr2 <= {1'b1, sr2[7:1]}.
  - Load has priority over shift. While strobe=1, every read returns the A button and no shift occurs.
- Serial sequence after the strobe falls: reads 1..8 return A,B,Select,Start,Up,Down,Left,Right. Read 9 and beyond return 1 indefinitely (the shift register saturates at 8'hFF).
- Cycle counting:
  - Every clk_ph1 cycle with rd1 true counts as one read.
  - A CPU dummy read or repeated address in consecutive cycles shifts once per cycle.
  - This is intended hardware-accurate behaviour.
- Pad independence: reading one port never shifts the other; the strobe is shared.
- Reset mid-sequence: the shift registers return to FF and strobe to 0. Reads then return 1 until a new strobe 1->0 sequence.
- Writes to PORT2_ADDR or any other address leave all state unchanged.

Test Plan:
- Reset, then read $4016 with no strobe -> rd_sel=1, rd_data=8'h41, repeated 3 times.
- pad1_btn=8'b1001_0101 held 3+ cycles; write $4016=01 then $4016=00; 9 reads of $4016 -> bit0 sequence 1,0,1,0,1,0,0,1,1 and rd_data[7:1]=7'b0100000 each time.
- strobe=1 held, pad1_btn toggles bit0 0->1 -> read returns 1 from the 3rd edge after the change (sync + load). Repeated reads do not shift: same value, strobe=1.
- pad2_btn=8'h80, strobe pulse, 8 reads of $4017 interleaved with reads of $4016 -> $4017 returns 0 x7 then 1, independent of pad1.
- Write $4017=01, or write $4016=FE -> strobe stays 0 and the shift registers are untouched. Read of $5000 -> rd_sel=0, rd_data=00.
- Assert rst after 3 shifts -> the next read returns 1 and strobe=0.
